serial_rx_package: RTL and testbench

SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

---
 rtl/serial_rx_package_pkg.sv | 30 +++
 rtl/serial_rx_package_rx_gap_timer.sv | 51 +++++
 rtl/serial_rx_package.sv | 207 ++++++++++++++++++++
 tb/tb_serial_rx_package.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_package_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_package_pkg
// Shared definitions for the serial packet receiver (and its TX counterpart):
//   - default start-of-frame byte and payload limits
//   - receiver FSM state encoding
//   - small helper to validate a received LEN byte
// No ports (package).
// -----------------------------------------------------------------------------
package serial_rx_package_pkg;

  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         MAX_LEN_DEFAULT = 64;
  localparam int         ADDR_W_DEFAULT  = 6;
  localparam int         TIMEOUT_DEFAULT = 100000;

  // Frame: SOF, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } rx_state_e;

  // A LEN byte is usable only when it is non-zero and fits the payload buffer.
  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/serial_rx_package_rx_gap_timer.sv
// -----------------------------------------------------------------------------
// rx_gap_timer
// Counts clock cycles in which 'enable' is high and 'clear' is low. 'expired'
// is a combinational flag raised during the TIMEOUT-th such cycle, so a
// consumer registering it acts on the same edge that would have counted the
// TIMEOUT-th idle cycle. 'clear' always wins over counting and expiry.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   clear   in  restart the count from zero
//   enable  in  count this cycle
//   expired out TIMEOUT-th consecutive enabled cycle is in progress
// -----------------------------------------------------------------------------
module rx_gap_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      // Saturate so a stalled consumer never sees the count wrap.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_rx_package.sv
// -----------------------------------------------------------------------------
// serial_rx_package
// Packet decoder sitting behind a byte-wide serial receiver. Frames are
//   SOF, CMD, LEN, LEN payload bytes, CHK   with CHK = CMD ^ LEN ^ payload.
// Payload bytes are streamed out as registered write strobes; the packet is
// then closed with a one-cycle pkt_done (checksum good) or pkt_err (bad LEN,
// bad checksum, or inter-byte timeout). Writes already issued are never
// retracted: the consumer discards the buffer on pkt_err.
//
// Optional feature: define SERIAL_RX_PACKAGE_TIMEOUT_EN to build an inter-byte
// gap timer (rx_gap_timer). Without it packets wait forever and TIMEOUT is
// ignored.
//
// Ports:
//   clk      in   system clock, all logic on rising edge
//   rst      in   synchronous active-high reset (wins over rx_valid)
//   rx_data  in   [7:0] received byte
//   rx_valid in   one-cycle strobe qualifying rx_data
//   wr_en    out  payload byte write strobe (one cycle per byte)
//   wr_addr  out  [ADDR_W-1:0] payload byte index, 0-based
//   wr_data  out  [7:0] payload byte
//   pkt_cmd  out  [7:0] command byte of current/last packet
//   pkt_len  out  [7:0] length byte of current/last packet
//   pkt_done out  one-cycle pulse: packet accepted, checksum good
//   pkt_err  out  one-cycle pulse: packet aborted
//   busy     out  high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module serial_rx_package
  import serial_rx_package_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = MAX_LEN_DEFAULT,
  parameter int         ADDR_W  = ADDR_W_DEFAULT,
  parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        pkt_cmd,
  output logic [7:0]        pkt_len,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              busy
);

  rx_state_e         state_q,    state_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [7:0]        wr_data_q,  wr_data_d;
  logic [7:0]        pkt_cmd_q,  pkt_cmd_d;
  logic [7:0]        pkt_len_q,  pkt_len_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_err_q,  pkt_err_d;
  logic [7:0]        chk_q,      chk_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;

  logic timeout_hit;
  logic last_payload;

  // -------------------------------------------------------------------------
  // Inter-byte gap timer (optional)
  // -------------------------------------------------------------------------
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  logic gap_clear;
  logic gap_enable;

  // A byte in the expiry cycle clears the timer and suppresses 'expired',
  // so the byte is processed instead of aborting the packet.
  assign gap_clear  = rx_valid || (state_q == ST_IDLE);
  assign gap_enable = (state_q != ST_IDLE) && !rx_valid;

  rx_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Compare in 32 bits so the check holds for any ADDR_W.
  assign last_payload = ((32'(idx_q) + 32'd1) == 32'(pkt_len_q));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pkt_cmd_d  = pkt_cmd_q;
    pkt_len_d  = pkt_len_q;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;
    chk_d      = chk_q;
    idx_d      = idx_q;

    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          // Line noise before a frame is dropped without reporting.
          if (rx_data == SOF) begin
            state_d = ST_CMD;
          end
        end

        ST_CMD: begin
          pkt_cmd_d = rx_data;
          chk_d     = rx_data;
          state_d   = ST_LEN;
        end

        ST_LEN: begin
          pkt_len_d = rx_data;
          chk_d     = chk_q ^ rx_data;
          if (len_ok(rx_data, MAX_LEN)) begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            pkt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end

        ST_PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rx_data;
          chk_d     = chk_q ^ rx_data;
          if (last_payload) begin
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end

        ST_CHECK: begin
          // chk_q already folds in CMD, LEN and every payload byte.
          if (rx_data == chk_q) begin
            pkt_done_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      pkt_err_d = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      pkt_cmd_q  <= 8'd0;
      pkt_len_q  <= 8'd0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      chk_q      <= 8'd0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pkt_cmd_q  <= pkt_cmd_d;
      pkt_len_q  <= pkt_len_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pkt_cmd  = pkt_cmd_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_done = pkt_done_q;
  assign pkt_err  = pkt_err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_package.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_package
// Self-checking bench for serial_rx_package. Byte streams are parsed by a
// frame-level reference model into an expected list of events (writes,
// done, err); the DUT's events are collected by a monitor and compared.
// Timeout scenarios run only when SERIAL_RX_PACKAGE_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_rx_package;

  localparam logic [7:0] SOF_B   = 8'hA5;
  localparam int         MAX_LEN = 64;
  localparam int         ADDR_W  = 6;
  localparam int         TO_CYC  = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        pkt_cmd;
  logic [7:0]        pkt_len;
  logic              pkt_done;
  logic              pkt_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int both_hi  = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  serial_rx_package #(
    .SOF     (SOF_B),
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TO_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pkt_cmd  (pkt_cmd),
    .pkt_len  (pkt_len),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .busy     (busy)
  );

  // Event encoding: {type, a, b, 0}; 1 = write {addr, data},
  // 2 = done {cmd, len}, 3 = err {cmd, len}.
  always @(negedge clk) begin
    if (wr_en === 1'b1)    obs_q.push_back({8'd1, 8'(wr_addr), wr_data, 8'd0});
    if (pkt_done === 1'b1) obs_q.push_back({8'd2, pkt_cmd, pkt_len, 8'd0});
    if (pkt_err === 1'b1)  obs_q.push_back({8'd3, pkt_cmd, pkt_len, 8'd0});
    if (pkt_done === 1'b1 && pkt_err === 1'b1) both_hi++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Frame-level reference: walk the stream, find frames, emit events.
  function automatic void model_stream();
    int i;
    logic [7:0] cmd, len, x;
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != SOF_B) begin
        i++;
        continue;
      end
      if (i + 2 >= stim_q.size()) break;
      cmd = stim_q[i+1];
      len = stim_q[i+2];
      i += 3;
      if (len == 0 || int'(len) > MAX_LEN) begin
        exp_q.push_back({8'd3, cmd, len, 8'd0});
        continue;
      end
      x = cmd ^ len;
      for (int k = 0; k < int'(len); k++) begin
        if (i >= stim_q.size()) return;
        exp_q.push_back({8'd1, 8'(k), stim_q[i], 8'd0});
        x ^= stim_q[i];
        i++;
      end
      if (i >= stim_q.size()) return;
      if (stim_q[i] == x) exp_q.push_back({8'd2, cmd, len, 8'd0});
      else                exp_q.push_back({8'd3, cmd, len, 8'd0});
      i++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_stim(input int max_gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) step();
      drive_byte(stim_q[i]);
    end
  endtask

  task automatic begin_scenario();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad length (header only)
  task automatic add_frame(input int kind, input int len);
    logic [7:0] cmd, x, b;
    cmd = 8'($urandom);
    stim_q.push_back(SOF_B);
    stim_q.push_back(cmd);
    if (kind == 2) begin
      if ($urandom_range(1, 0) == 0) stim_q.push_back(8'd0);
      else stim_q.push_back(8'($urandom_range(255, MAX_LEN + 1)));
      return;
    end
    stim_q.push_back(8'(len));
    x = cmd ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      x ^= b;
    end
    stim_q.push_back((kind == 1) ? ~x : x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (3) step();
    n_checks++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    n_checks++; if (wr_addr !== '0)    begin n_fail++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
    n_checks++; if (wr_data !== 8'd0)  begin n_fail++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
    n_checks++; if (pkt_cmd !== 8'd0)  begin n_fail++; $display("FAIL reset_pkt_cmd: got %h required 0", pkt_cmd); end
    n_checks++; if (pkt_len !== 8'd0)  begin n_fail++; $display("FAIL reset_pkt_len: got %h required 0", pkt_len); end
    n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b required 0", pkt_done); end
    n_checks++; if (pkt_err !== 1'b0)  begin n_fail++; $display("FAIL reset_pkt_err: got %b required 0", pkt_err); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    // SOF presented while in reset must be ignored.
    drive_byte(SOF_B);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_priority_busy: got %b required 0", busy); end
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    begin_scenario();
    stim_q = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
    drive_byte(stim_q[0]);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_sof: got %b required 1", busy); end
    for (int i = 1; i < stim_q.size(); i++) drive_byte(stim_q[i]);
    n_checks++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: got %b required 1", pkt_done); end
    repeat (4) step();
    n_checks++; if (pkt_cmd !== 8'h01) begin n_fail++; $display("FAIL basic_pkt_cmd: got %h required 01", pkt_cmd); end
    n_checks++; if (pkt_len !== 8'h03) begin n_fail++; $display("FAIL basic_pkt_len: got %h required 03", pkt_len); end
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_basic: %0d events", obs_q.size());
  endtask

  task automatic test_bad_chk();
    begin_scenario();
    stim_q = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'hFF};
    send_stim(0);
    n_checks++; if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL badchk_err_timing: got %b required 1", pkt_err); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL badchk_busy: got %b required 0", busy); end
    step();
    n_checks++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL badchk_err_pulse_width: got %b required 0", pkt_err); end
    repeat (3) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL badchk_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badchk_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_bad_chk: %0d events", obs_q.size());
  endtask

  task automatic test_junk_len0();
    begin_scenario();
    stim_q = '{8'h00, 8'h5A, 8'hA5, 8'h07, 8'h00};
    add_frame(0, 2);
    send_stim(2);
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL junk_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL junk_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_junk_len0: %0d events", obs_q.size());
  endtask

  task automatic test_len_overflow();
    begin_scenario();
    stim_q = '{8'hA5, 8'h3C, 8'(MAX_LEN + 1)};
    send_stim(0);
    n_checks++; if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL lenovf_err_timing: got %b required 1", pkt_err); end
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL lenovf_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lenovf_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_len_overflow: %0d events", obs_q.size());
  endtask

  task automatic test_random();
    int kind, len;
    begin_scenario();
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(2, 0)) begin
        logic [7:0] j;
        j = 8'($urandom);
        stim_q.push_back((j == SOF_B) ? 8'h00 : j);
      end
      kind = ($urandom_range(9, 0) < 6) ? 0 : int'($urandom_range(2, 1));
      case ($urandom_range(3, 0))
        0:       len = 1;
        1:       len = MAX_LEN;
        default: len = int'($urandom_range(MAX_LEN, 1));
      endcase
      add_frame(kind, len);
    end
    send_stim(2);
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_random: %0d bytes, %0d events", stim_q.size(), obs_q.size());
  endtask

  task automatic test_back_to_back();
    begin_scenario();
    add_frame(0, 1);
    add_frame(0, MAX_LEN);
    add_frame(1, 5);
    add_frame(0, int'($urandom_range(MAX_LEN, 1)));
    add_frame(2, 0);
    add_frame(0, 3);
    send_stim(0);
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_back_to_back: %0d bytes, %0d events", stim_q.size(), obs_q.size());
  endtask

  task automatic test_reset_mid();
    begin_scenario();
    stim_q = '{8'hA5, 8'h44, 8'h04, 8'h9A, 8'h7E};
    send_stim(0);
    model_stream();
    rst = 1'b1;
    step();
    n_checks++; if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL rstmid_wr_en: got %b required 0", wr_en); end
    n_checks++; if (wr_addr !== '0)   begin n_fail++; $display("FAIL rstmid_wr_addr: got %h required 0", wr_addr); end
    n_checks++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL rstmid_wr_data: got %h required 0", wr_data); end
    n_checks++; if (pkt_cmd !== 8'd0) begin n_fail++; $display("FAIL rstmid_pkt_cmd: got %h required 0", pkt_cmd); end
    n_checks++; if (pkt_len !== 8'd0) begin n_fail++; $display("FAIL rstmid_pkt_len: got %h required 0", pkt_len); end
    n_checks++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pkt_err: got %b required 0", pkt_err); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    rst = 1'b0;
    step();
    stim_q.delete();
    add_frame(0, 4);
    send_stim(1);
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_reset_mid: %0d events", obs_q.size());
  endtask

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  task automatic test_timeout();
    int seen_at;
    logic [7:0] chk;
    // Part 1: stall after the second payload byte.
    begin_scenario();
    stim_q = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
    send_stim(0);
    seen_at = -1;
    for (int k = 1; k <= TO_CYC + 10; k++) begin
      step();
      if (pkt_err === 1'b1) begin
        seen_at = k;
        break;
      end
    end
    n_checks++; if (seen_at != TO_CYC) begin n_fail++; $display("FAIL timeout_latency: got %0d required %0d", seen_at, TO_CYC); end
    repeat (3) step();
    model_stream();
    exp_q.push_back({8'd3, 8'h01, 8'h04, 8'd0});
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    // Part 2: a byte in the expiry cycle is accepted.
    begin_scenario();
    stim_q = '{8'hA5, 8'h02, 8'h03, 8'h33, 8'h44};
    send_stim(0);
    repeat (TO_CYC - 1) step();
    drive_byte(8'h55);
    chk = 8'h02 ^ 8'h03 ^ 8'h33 ^ 8'h44 ^ 8'h55;
    drive_byte(chk);
    stim_q.push_back(8'h55);
    stim_q.push_back(chk);
    repeat (4) step();
    model_stream();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_race_event_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_race_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_timeout: latency %0d", seen_at);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_junk_len0();
    test_len_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (both_hi != 0) begin n_fail++; $display("FAIL done_err_exclusive: got %0d overlapping cycles required 0", both_hi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
